free_list: RTL and testbench

- Physical-register free list for the rename stage.
- Supplies free physical register numbers to the register alias table for each renamed instruction that writes a destination.
- Reclaims the previous physical destinations when their overwriting instructions commit.
- On a pipeline flush, rolls the speculative read pointer back to the committed (architectural) position.
- Implemented as a circular FIFO with speculative head, architectural head and tail pointers.

---
 rtl/free_list_pkg.sv | 43 ++++
 rtl/free_list_if.sv | 64 ++++++
 rtl/free_list_prefix_sum.sv | 33 +++
 rtl/free_list.sv | 144 ++++++++++++++
 tb/tb_free_list.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/free_list_pkg.sv
// ---------------------------------------------------------------------------
// free_list_pkg
//   Shared types and constants for the physical-register free list.
//
//   PHY_REG_NUM   number of physical registers (power of two)
//   DECODE_WIDTH  allocation lanes per cycle
//   COMMIT_WIDTH  commit / free lanes per cycle
//   preg_t        physical register number
//   fl_ptr_t      circular-buffer pointer: index bits plus one wrap bit
//   FL_PTR_W      width of fl_ptr_t
//
//   The sizes live here rather than as module parameters because the
//   interface and the types it carries are built from them; change them here
//   to resize the whole slice consistently.
// ---------------------------------------------------------------------------
package free_list_pkg;

  localparam int PHY_REG_NUM  = 64;
  localparam int DECODE_WIDTH = 4;
  localparam int COMMIT_WIDTH = 4;

  localparam int PREG_W   = $clog2(PHY_REG_NUM);
  localparam int FL_PTR_W = PREG_W + 1;

  // Lane-count width, large enough for a full popcount of the widest lane set.
  localparam int MAX_LANES = (DECODE_WIDTH > COMMIT_WIDTH) ? DECODE_WIDTH : COMMIT_WIDTH;
  localparam int CNT_W     = $clog2(MAX_LANES + 1);

  typedef logic [PREG_W-1:0]   preg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [CNT_W-1:0]    lane_cnt_t;

  // Population count of a commit-lane vector.
  function automatic lane_cnt_t fl_popcount(input logic [COMMIT_WIDTH-1:0] v);
    lane_cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      cnt = cnt + lane_cnt_t'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/free_list_if.sv
// ---------------------------------------------------------------------------
// free_list_if
//   Bundle between the rename / commit logic (master) and the free list
//   (slave).
//
//   Handshake: lane i of an allocation transfers in a cycle exactly when
//   alloc_valid_i[i] && alloc_ready_o. alloc_ready_o never depends on
//   alloc_valid_i, and the granted preg_o[i] is valid in that same cycle.
//   Commit and free lanes have no back-pressure; they always take effect.
//
//   alloc_valid_i  per-lane allocation request
//   alloc_ready_o  allocation accepted this cycle (all lanes together)
//   preg_o         granted preg per lane, 0 for lanes not firing
//   commit_dest_i  committing instruction had a destination
//   free_i         committing instruction releases an old preg
//   free_preg_i    preg being released per lane
//   restore_i      flush: roll speculative head back
//   free_cnt_o     entries currently available
//   stall_cnt_o    (FREE_LIST_STALL_STAT_EN only) blocked-request cycle count
// ---------------------------------------------------------------------------
interface free_list_if;
  import free_list_pkg::*;

  logic [DECODE_WIDTH-1:0]        alloc_valid_i;
  logic                           alloc_ready_o;
  preg_t [DECODE_WIDTH-1:0]       preg_o;
  logic [COMMIT_WIDTH-1:0]        commit_dest_i;
  logic [COMMIT_WIDTH-1:0]        free_i;
  preg_t [COMMIT_WIDTH-1:0]       free_preg_i;
  logic                           restore_i;
  fl_ptr_t                        free_cnt_o;
`ifdef FREE_LIST_STALL_STAT_EN
  logic [31:0]                    stall_cnt_o;
`endif

  modport master (
    output alloc_valid_i,
    input  alloc_ready_o,
    input  preg_o,
    output commit_dest_i,
    output free_i,
    output free_preg_i,
    output restore_i,
`ifdef FREE_LIST_STALL_STAT_EN
    input  stall_cnt_o,
`endif
    input  free_cnt_o
  );

  modport slave (
    input  alloc_valid_i,
    output alloc_ready_o,
    output preg_o,
    input  commit_dest_i,
    input  free_i,
    input  free_preg_i,
    input  restore_i,
`ifdef FREE_LIST_STALL_STAT_EN
    output stall_cnt_o,
`endif
    output free_cnt_o
  );

endinterface

// File: rtl/free_list_prefix_sum.sv
// ---------------------------------------------------------------------------
// free_list_prefix_sum
//   Exclusive prefix count over a lane-valid vector plus its total popcount.
//   prefix[i] = number of set bits in vld[i-1:0]; used to pack valid lanes
//   onto consecutive FIFO slots in lane order.
//
//   N      number of lanes
//   CW     count width (must hold N)
//   vld    lane valid vector
//   prefix per-lane exclusive count
//   total  popcount of vld
// ---------------------------------------------------------------------------
module free_list_prefix_sum #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic [N-1:0]         vld,
  output logic [N-1:0][CW-1:0] prefix,
  output logic [CW-1:0]        total
);

  always_comb begin
    logic [CW-1:0] run;
    run    = '0;
    prefix = '0;
    for (int i = 0; i < N; i++) begin
      prefix[i] = run;
      run       = run + CW'(vld[i]);
    end
    total = run;
  end

endmodule

// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
//   Physical-register free list for the rename stage. A circular FIFO of
//   preg numbers with three pointers:
//     head_q       speculative read pointer (advanced by allocation)
//     arch_head_q  committed read pointer (advanced by commits with a dest)
//     tail_q       write pointer (advanced by frees)
//   All pointers carry a wrap bit, so count = tail_q - head_q modulo
//   2*PHY_REG_NUM distinguishes full from empty. A flush snaps head_q back to
//   arch_head_q plus this cycle's commits.
//
//   Optional build macro FREE_LIST_STALL_STAT_EN adds a saturating 32-bit
//   count of cycles in which some lane requested but allocation was refused.
//
//   clk    clock
//   rst_n  asynchronous active-low reset (list full, slot k holds k)
//   fl     free_list_if slave modport (see interface header for signals)
// ---------------------------------------------------------------------------
module free_list
  import free_list_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  free_list_if.slave    fl
);

  localparam int SUM_W = FL_PTR_W + 1;

  preg_t   slot_q [PHY_REG_NUM];
  fl_ptr_t head_q;
  fl_ptr_t arch_head_q;
  fl_ptr_t tail_q;

  fl_ptr_t                    count;
  logic                       alloc_ready;
  logic [DECODE_WIDTH-1:0]    fire;
  logic [DECODE_WIDTH-1:0][CNT_W-1:0] alloc_prefix;
  logic [CNT_W-1:0]           alloc_total;
  logic [COMMIT_WIDTH-1:0][CNT_W-1:0] free_prefix;
  logic [CNT_W-1:0]           free_total;
  lane_cnt_t                  commit_total;
  preg_t [DECODE_WIDTH-1:0]   preg;
  preg_t [COMMIT_WIDTH-1:0]   wr_idx;

  assign count = tail_q - head_q;

  // Conservative: only grant when every lane could be served, so ready does
  // not look at alloc_valid_i and no combinational loop forms with rename.
  assign alloc_ready = (count >= FL_PTR_W'(DECODE_WIDTH)) && !fl.restore_i;
  assign fire        = fl.alloc_valid_i & {DECODE_WIDTH{alloc_ready}};

  free_list_prefix_sum #(.N(DECODE_WIDTH), .CW(CNT_W)) u_alloc_sum (
    .vld    (fire),
    .prefix (alloc_prefix),
    .total  (alloc_total)
  );

  free_list_prefix_sum #(.N(COMMIT_WIDTH), .CW(CNT_W)) u_free_sum (
    .vld    (fl.free_i),
    .prefix (free_prefix),
    .total  (free_total)
  );

  assign commit_total = fl_popcount(fl.commit_dest_i);

  // Read ports: firing lanes take consecutive slots starting at head.
  always_comb begin
    preg_t idx;
    idx  = '0;
    preg = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      idx = head_q[PREG_W-1:0] + PREG_W'(alloc_prefix[i]);
      if (fire[i]) begin
        preg[i] = slot_q[idx];
      end
    end
  end

  // Write ports: freeing lanes fill consecutive slots starting at tail.
  always_comb begin
    wr_idx = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      wr_idx[j] = tail_q[PREG_W-1:0] + PREG_W'(free_prefix[j]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PHY_REG_NUM; k++) begin
        slot_q[k] <= preg_t'(k);
      end
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (fl.free_i[j]) begin
          slot_q[wr_idx[j]] <= fl.free_preg_i[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= fl_ptr_t'(PHY_REG_NUM);
    end else begin
      // Restore includes the commits of the flush cycle itself.
      if (fl.restore_i) begin
        head_q <= arch_head_q + fl_ptr_t'(commit_total);
      end else begin
        head_q <= head_q + fl_ptr_t'(alloc_total);
      end
      arch_head_q <= arch_head_q + fl_ptr_t'(commit_total);
      tail_q      <= tail_q + fl_ptr_t'(free_total);
    end
  end

  assign fl.alloc_ready_o = alloc_ready;
  assign fl.preg_o        = preg;
  assign fl.free_cnt_o    = count;

`ifdef FREE_LIST_STALL_STAT_EN
  logic [31:0] stall_cnt_q;
  logic        stall;

  assign stall = (|fl.alloc_valid_i) && !alloc_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fl.stall_cnt_o = stall_cnt_q;
`endif

  // More frees than there are empty slots means a preg was released twice.
  assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, count} + SUM_W'(free_total)) <= SUM_W'(PHY_REG_NUM))
    else $error("free_list overflow: count=%0d frees=%0d", count, free_total);

endmodule

// File: tb/tb_free_list.sv
// ---------------------------------------------------------------------------
// tb_free_list
//   Directed bench for free_list. Inputs change on the falling edge; the
//   combinational outputs and the registered count are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_free_list;
  import free_list_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  free_list_if fl_if ();

  free_list dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fl    (fl_if)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // ---------------- check / driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    fl_if.alloc_valid_i = '0;
    fl_if.commit_dest_i = '0;
    fl_if.free_i        = '0;
    fl_if.restore_i     = 1'b0;
  endtask

  // One cycle of stimulus: apply on the falling edge, settle 1 ns.
  task automatic step(input logic [3:0] av, input logic [3:0] cd,
                      input logic [3:0] fr, input logic rs);
    @(negedge clk);
    fl_if.alloc_valid_i = av;
    fl_if.commit_dest_i = cd;
    fl_if.free_i        = fr;
    fl_if.restore_i     = rs;
    #1;
  endtask

  // Reset asserted mid-cycle: state must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_cnt"}, 32'(fl_if.free_cnt_o), 32'd64);
    chk({tag, "_rst_rdy"}, 32'(fl_if.alloc_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    fl_if.free_preg_i = '0;
    repeat (2) @(negedge clk);
    chk("init_cnt", 32'(fl_if.free_cnt_o), 32'd64);
    chk("init_rdy", 32'(fl_if.alloc_ready_o), 32'd1);
    rst_n = 1'b1;

    // Full-width allocation from reset.
    step(4'b1111, 4'b0000, 4'b0000, 1'b0);
    chk("t1_p0", 32'(fl_if.preg_o[0]), 32'd0);
    chk("t1_p1", 32'(fl_if.preg_o[1]), 32'd1);
    chk("t1_p2", 32'(fl_if.preg_o[2]), 32'd2);
    chk("t1_p3", 32'(fl_if.preg_o[3]), 32'd3);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("t1_cnt", 32'(fl_if.free_cnt_o), 32'd60);

    // Sparse lanes pack onto consecutive slots.
    do_reset("t2");
    step(4'b1010, 4'b0000, 4'b0000, 1'b0);
    chk("t2_p0", 32'(fl_if.preg_o[0]), 32'd0);
    chk("t2_p1", 32'(fl_if.preg_o[1]), 32'd0);
    chk("t2_p2", 32'(fl_if.preg_o[2]), 32'd0);
    chk("t2_p3", 32'(fl_if.preg_o[3]), 32'd1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("t2_cnt", 32'(fl_if.free_cnt_o), 32'd62);

    // Drain to 3 entries: ready drops, head holds, a free re-enables.
    step(4'b1111, 4'b0000, 4'b0000, 1'b0);
    chk("t3_first_p0", 32'(fl_if.preg_o[0]), 32'd2);
    repeat (13) step(4'b1111, 4'b0000, 4'b0000, 1'b0);
    step(4'b0111, 4'b0000, 4'b0000, 1'b0);
    chk("t3_p2", 32'(fl_if.preg_o[2]), 32'd60);
    step(4'b1111, 4'b0000, 4'b0000, 1'b0);
    chk("t3_cnt3", 32'(fl_if.free_cnt_o), 32'd3);
    chk("t3_rdy0", 32'(fl_if.alloc_ready_o), 32'd0);
    chk("t3_blocked_p0", 32'(fl_if.preg_o[0]), 32'd0);
    fl_if.free_preg_i[0] = preg_t'(5);
    step(4'b0000, 4'b0000, 4'b0001, 1'b0);
    chk("t3_hold_cnt", 32'(fl_if.free_cnt_o), 32'd3);
    chk("t3_hold_rdy", 32'(fl_if.alloc_ready_o), 32'd0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("t3_free_cnt", 32'(fl_if.free_cnt_o), 32'd4);
    chk("t3_free_rdy", 32'(fl_if.alloc_ready_o), 32'd1);

    // Allocate 8, commit 3 (2 then 1 in the flush cycle), restore.
    do_reset("t4");
    step(4'b1111, 4'b0011, 4'b0000, 1'b0);
    step(4'b1111, 4'b0000, 4'b0000, 1'b0);
    step(4'b1111, 4'b0001, 4'b0000, 1'b1);
    chk("t4_restore_rdy", 32'(fl_if.alloc_ready_o), 32'd0);
    chk("t4_restore_p0", 32'(fl_if.preg_o[0]), 32'd0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0);
    chk("t4_cnt", 32'(fl_if.free_cnt_o), 32'd61);
    chk("t4_p0", 32'(fl_if.preg_o[0]), 32'd3);

    // Alloc 2 + free 3 at count 10, then walk across the wrap.
    do_reset("t5");
    repeat (13) step(4'b1111, 4'b0000, 4'b0000, 1'b0);
    step(4'b0011, 4'b0000, 4'b0000, 1'b0);
    fl_if.free_preg_i[0] = preg_t'(40);
    fl_if.free_preg_i[1] = preg_t'(41);
    fl_if.free_preg_i[2] = preg_t'(42);
    exp_q.push_back(32'd40);
    exp_q.push_back(32'd41);
    exp_q.push_back(32'd42);
    step(4'b0011, 4'b0000, 4'b0111, 1'b0);
    chk("t5_cnt10", 32'(fl_if.free_cnt_o), 32'd10);
    chk("t5_p0", 32'(fl_if.preg_o[0]), 32'd54);
    chk("t5_p1", 32'(fl_if.preg_o[1]), 32'd55);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("t5_cnt11", 32'(fl_if.free_cnt_o), 32'd11);
    step(4'b1111, 4'b0000, 4'b0000, 1'b0);
    chk("t5_a_p0", 32'(fl_if.preg_o[0]), 32'd56);
    step(4'b1111, 4'b0000, 4'b0000, 1'b0);
    chk("t5_b_p3", 32'(fl_if.preg_o[3]), 32'd63);
    fl_if.free_preg_i[0] = preg_t'(43);
    exp_q.push_back(32'd43);
    step(4'b0000, 4'b0000, 4'b0001, 1'b0);
    step(4'b1111, 4'b0000, 4'b0000, 1'b0);
    chk("t5_wrap_rdy", 32'(fl_if.alloc_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_wrap_p%0d", i), 32'(fl_if.preg_o[i]), exp_q.pop_front());
    end
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("t5_empty_cnt", 32'(fl_if.free_cnt_o), 32'd0);
    chk("t5_empty_rdy", 32'(fl_if.alloc_ready_o), 32'd0);

`ifdef FREE_LIST_STALL_STAT_EN
    // Seven refused cycles (held off by restore), then an accepted one.
    do_reset("t6");
    chk("t6_stall0", fl_if.stall_cnt_o, 32'd0);
    repeat (7) step(4'b0001, 4'b0000, 4'b0000, 1'b1);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0);
    chk("t6_stall7", fl_if.stall_cnt_o, 32'd7);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("t6_stall_hold", fl_if.stall_cnt_o, 32'd7);
`endif

    step(4'b0000, 4'b0000, 4'b0000, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
